// File: rtl/sobel_pkg.sv
// Shared Sobel types and arithmetic: window struct, gradient magnitude helper.
// Latency: n/a (package of types and pure functions).
// Backpressure: n/a.
package sobel_pkg;

    // Window pixels are carried at a fixed width so the shared helper works for
    // any PIX_W up to 16; narrower pixels are zero-extended into it.
    localparam int WIN_PIX_W = 16;
    localparam int GRAD_W    = WIN_PIX_W + 3;
    localparam int SUM_W     = WIN_PIX_W + 4;

    typedef logic [WIN_PIX_W-1:0] win_pix_t;

    // Row-major 3x3 window, p0 = top-left, p4 = centre, p8 = bottom-right.
    typedef struct packed {
        win_pix_t p0, p1, p2;
        win_pix_t p3, p4, p5;
        win_pix_t p6, p7, p8;
    } win_t;

    function automatic int mag_w(input int pix_w);
        return pix_w + 4;
    endfunction

    // |gx| + |gy| with gx = right - left column, gy = top - bottom row.
    function automatic logic [SUM_W-1:0] sobel_abs_sum(input win_t w);
        logic        [GRAD_W-1:0] xp, xn, yp, yn, ax, ay;
        logic signed [GRAD_W-1:0] gx, gy;
        xp = GRAD_W'(w.p2) + GRAD_W'({w.p5, 1'b0}) + GRAD_W'(w.p8);
        xn = GRAD_W'(w.p0) + GRAD_W'({w.p3, 1'b0}) + GRAD_W'(w.p6);
        yp = GRAD_W'(w.p0) + GRAD_W'({w.p1, 1'b0}) + GRAD_W'(w.p2);
        yn = GRAD_W'(w.p6) + GRAD_W'({w.p7, 1'b0}) + GRAD_W'(w.p8);
        // Each partial sum is below 2^(WIN_PIX_W+2), so the difference always
        // fits the signed GRAD_W range and the wrap-around subtract is exact.
        gx = $signed(xp - xn);
        gy = $signed(yp - yn);
        ax = gx[GRAD_W-1] ? $unsigned(-gx) : $unsigned(gx);
        ay = gy[GRAD_W-1] ? $unsigned(-gy) : $unsigned(gy);
        return SUM_W'(ax) + SUM_W'(ay);
    endfunction

endpackage

// File: rtl/sobel_linebuf.sv
// One video line of storage, indexed by column, read-before-write.
// Latency: read is combinational, write lands on the clock edge.
// Backpressure: none; the owner gates wr_en with its accept strobe.
// Ports: clk; wr_en, addr, wr_dat (write side); rd_dat (old contents of addr).
module sobel_linebuf #(
    parameter  int DEPTH = 640,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wr_dat,
    output logic [W-1:0]  rd_dat
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [W-1:0] mem [DEPTH];

    assign rd_dat = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector; one edge bit per interior pixel, two line buffers.
// Latency: pixel accepted on edge E0 shows its result after E2 when not stalled.
// Backpressure: single global stall, in_ready = !out_valid || out_ready; all stages share it.
// Ports: clk/rst_n; in_valid/in_ready/in_pixel/in_sof (pixel stream); threshold;
//        out_valid/out_ready/out_edge/out_last/out_mag (result stream).
// Option: define SOBEL_MAG_OUT_EN to register the magnitude onto out_mag (else tied 0).
module sobel_stream
    import sobel_pkg::*;
#(
    parameter  int PIX_W = 8,
    parameter  int IMG_W = 640,
    parameter  int IMG_H = 480,
    localparam int MAG_W = mag_w(PIX_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_sof,
    input  logic [MAG_W-1:0] threshold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_edge,
    output logic             out_last,
    output logic [MAG_W-1:0] out_mag
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic             acc;
    logic [CW-1:0]    col, cur_col;
    logic [RW-1:0]    row, cur_row;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    win_t             win;
    logic             s1_vld, s1_last;
    logic [MAG_W-1:0] mag;
    logic             s2_vld, s2_last;

    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;

    // A start-of-frame pixel is position (0,0) regardless of the counters.
    assign cur_col = in_sof ? '0 : col;
    assign cur_row = in_sof ? '0 : row;

    // lb0 holds the previous line, lb1 the one before; lb1 is fed lb0's old word.
    sobel_linebuf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb0 (
        .clk    (clk),
        .wr_en  (acc),
        .addr   (cur_col),
        .wr_dat (in_pixel),
        .rd_dat (lb0_rd)
    );

    sobel_linebuf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb1 (
        .clk    (clk),
        .wr_en  (acc),
        .addr   (cur_col),
        .wr_dat (lb0_rd),
        .rd_dat (lb1_rd)
    );

    // Stage 1: position tracking and window shift. Non-accept cycles that still
    // advance the pipeline push an invalid bubble so nothing is repeated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col     <= '0;
            row     <= '0;
            win     <= '0;
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
        end else if (in_ready) begin
            // Border suppression also masks any window left over from an aborted frame.
            s1_vld  <= acc && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
            s1_last <= acc && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
            if (acc) begin
                win.p0 <= win.p1;
                win.p1 <= win.p2;
                win.p2 <= WIN_PIX_W'(lb1_rd);
                win.p3 <= win.p4;
                win.p4 <= win.p5;
                win.p5 <= WIN_PIX_W'(lb0_rd);
                win.p6 <= win.p7;
                win.p7 <= win.p8;
                win.p8 <= WIN_PIX_W'(in_pixel);
                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
            end
        end
    end

    // Stage 2: gradient magnitude; the sum never exceeds 8*(2^PIX_W-1), so it fits MAG_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag     <= '0;
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
        end else if (in_ready) begin
            mag     <= MAG_W'(sobel_abs_sum(win));
            s2_vld  <= s1_vld;
            s2_last <= s1_last;
        end
    end

    // Stage 3: threshold compare and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_edge  <= 1'b0;
            out_last  <= 1'b0;
        end else if (in_ready) begin
            out_valid <= s2_vld;
            out_edge  <= (mag > threshold);
            out_last  <= s2_last;
        end
    end

`ifdef SOBEL_MAG_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_mag <= '0;
        end else if (in_ready) begin
            out_mag <= mag;
        end
    end
`else
    assign out_mag = '0;
`endif

endmodule
